// File: rtl/cpu_sram_arbiter.sv
// Arbitrates one SRAM-like memory port between instruction fetch and data access.
// One transaction in flight; round-robin grant, data side wins ties after reset.
module cpu_sram_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {IDLE, ADDR, RESP} state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;  // 1 = data side owns the transaction
  logic   last_q, last_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    m_req        = 1'b0;
    m_wr         = 1'b0;
    m_size       = 2'd0;
    m_wstrb      = 4'd0;
    m_addr       = 32'd0;
    m_wdata      = 32'd0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    inst_rdata   = m_rdata;
    data_rdata   = m_rdata;

    case (state_q)
      IDLE: begin
        if (inst_req || data_req) begin
          state_d = ADDR;
          // On a tie the side that did not own the last transaction wins.
          owner_d = data_req & (~inst_req | ~last_q);
        end
      end
      ADDR: begin
        m_req = 1'b1;
        if (owner_q) begin
          m_wr    = data_wr;
          m_size  = data_size;
          m_wstrb = data_wstrb;
          m_addr  = data_addr;
          m_wdata = data_wdata;
        end else begin
          m_size  = 2'd2;
          m_addr  = inst_addr;
        end
        if (m_addr_ok) begin
          inst_addr_ok = ~owner_q;
          data_addr_ok = owner_q;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (m_data_ok) begin
          inst_data_ok = ~owner_q;
          data_data_ok = owner_q;
          last_d       = owner_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// Directed bench for cpu_sram_arbiter: transaction-level reference model checked every
// cycle, plus literal expectations for each directed scenario.
module tb_cpu_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata;
  logic        m_addr_ok, m_data_ok;
  logic [31:0] m_rdata;

  always #5 clk = ~clk;

  cpu_sram_arbiter dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: an open transaction, whether its address was taken, who owns it.
  bit mb_busy, mb_acc, mb_owner, mb_last;
  bit en = 1'b0;
  bit rec_en = 1'b0;
  int grants[$];

  always @(posedge clk) begin
    if (reset) begin
      mb_busy  <= 1'b0;
      mb_acc   <= 1'b0;
      mb_owner <= 1'b0;
      mb_last  <= 1'b0;
    end else if (!mb_busy) begin
      if (inst_req && data_req) begin
        mb_busy  <= 1'b1;
        mb_owner <= !mb_last;
      end else if (inst_req || data_req) begin
        mb_busy  <= 1'b1;
        mb_owner <= data_req;
      end
    end else if (!mb_acc) begin
      if (m_addr_ok) mb_acc <= 1'b1;
    end else if (m_data_ok) begin
      mb_busy <= 1'b0;
      mb_acc  <= 1'b0;
      mb_last <= mb_owner;
    end
  end

  always @(negedge clk) begin
    logic        e_req;
    logic [31:0] e_addr;
    logic [38:0] e_side;
    logic [3:0]  e_oks;
    if (en) begin
      e_req  = mb_busy && !mb_acc;
      e_addr = !e_req ? 32'd0 : (mb_owner ? data_addr : inst_addr);
      if (!e_req)        e_side = '0;
      else if (mb_owner) e_side = {data_wr, data_size, data_wstrb, data_wdata};
      else               e_side = {1'b0, 2'd2, 4'd0, 32'd0};
      e_oks = {e_req && !mb_owner && m_addr_ok, e_req && mb_owner && m_addr_ok,
               mb_acc && !mb_owner && m_data_ok, mb_acc && mb_owner && m_data_ok};
      chk("model_m_req", m_req, e_req);
      chk("model_m_addr", m_addr, e_addr);
      chk("model_m_side", {m_wr, m_size, m_wstrb, m_wdata}, e_side);
      chk("model_oks", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, e_oks);
      chk("model_rdata", {inst_rdata, data_rdata}, {m_rdata, m_rdata});
      if (rec_en) begin
        if (data_addr_ok) grants.push_back(1);
        if (inst_addr_ok) grants.push_back(0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_g[6];
    exp_g = '{1, 0, 1, 0, 1, 0};
    reset = 1'b1; inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0;
    data_size = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
    tick();
    en = 1'b1;
    tick();
    @(negedge clk);
    chk("reset_outputs", {m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, '0);
    tick();
    reset = 1'b0;

    // Single load
    data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h1000;
    tick();
    @(negedge clk);
    chk("load_c1_m_req", m_req, 1'b1);
    chk("load_c1_m_addr", m_addr, 32'h1000);
    tick();
    m_addr_ok = 1;
    @(negedge clk);
    chk("load_c2_addr_ok", {m_req, data_addr_ok, inst_addr_ok}, 3'b110);
    tick();
    m_addr_ok = 0; data_req = 0;
    @(negedge clk);
    chk("load_c3_m_req", m_req, 1'b0);
    tick();
    m_data_ok = 1; m_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("load_c4_data_ok", {data_data_ok, inst_data_ok}, 2'b10);
    chk("load_c4_rdata", data_rdata, 32'hDEADBEEF);
    tick();
    m_data_ok = 0;

    // Simultaneous requests after reset: grants alternate starting with data
    reset = 1;
    tick();
    reset = 0;
    inst_req = 1; inst_addr = 32'h400; data_req = 1; data_addr = 32'h3000;
    m_addr_ok = 1; m_data_ok = 1; rec_en = 1;
    repeat (18) tick();
    inst_req = 0; data_req = 0; m_addr_ok = 0; m_data_ok = 0;
    tick();
    rec_en = 0;
    chk("alt_grant_count", grants.size(), 6);
    for (int i = 0; i < 6 && i < grants.size(); i++)
      chk("alt_grant_order", grants[i], exp_g[i]);

    // Store sideband passthrough
    data_req = 1; data_wr = 1; data_size = 0; data_wstrb = 4'b0100;
    data_wdata = 32'h00AB0000; data_addr = 32'h2002;
    tick();
    @(negedge clk);
    chk("store_fields", {m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata},
        {1'b1, 1'b1, 2'd0, 4'b0100, 32'h2002, 32'h00AB0000});
    tick();
    m_addr_ok = 1;
    @(negedge clk);
    chk("store_addr_ok", data_addr_ok, 1'b1);
    tick();
    m_addr_ok = 0; data_req = 0; data_wr = 0; data_wstrb = 0; data_wdata = 0;
    tick();
    m_data_ok = 1;
    @(negedge clk);
    chk("store_data_ok", {data_data_ok, inst_data_ok}, 2'b10);
    tick();
    m_data_ok = 0;

    // Stalled memory port during a fetch, data request arrives meanwhile
    inst_req = 1; inst_addr = 32'hBFC00010; data_size = 2;
    tick();
    data_req = 1; data_addr = 32'h5000;
    repeat (10) begin
      tick();
      @(negedge clk);
      chk("stall_hold", {m_req, m_addr, m_size}, {1'b1, 32'hBFC00010, 2'd2});
    end
    tick();
    m_addr_ok = 1;
    @(negedge clk);
    chk("stall_inst_accept", {inst_addr_ok, data_addr_ok}, 2'b10);
    tick();
    m_addr_ok = 0; inst_req = 0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_resp_no_req", {m_req, data_addr_ok}, 2'b00);
      tick();
    end
    m_data_ok = 1; m_rdata = 32'h24020001;
    @(negedge clk);
    chk("stall_fetch_done", {inst_data_ok, data_data_ok, inst_rdata}, {2'b10, 32'h24020001});
    tick();
    m_data_ok = 0;
    tick();
    m_addr_ok = 1;
    @(negedge clk);
    chk("stall_data_grant", {m_req, m_addr, data_addr_ok}, {1'b1, 32'h5000, 1'b1});
    tick();
    m_addr_ok = 0; data_req = 0; m_data_ok = 1;
    @(negedge clk);
    chk("stall_data_done", data_data_ok, 1'b1);
    tick();
    m_data_ok = 0;

    // Stray response in IDLE
    m_data_ok = 1; m_rdata = 32'h12345678;
    @(negedge clk);
    chk("stray_no_pulse", {inst_data_ok, data_data_ok, m_req}, 3'b000);
    tick();
    m_data_ok = 0;
    @(negedge clk);
    chk("stray_still_idle", m_req, 1'b0);

    // Reset while in RESP (last currently = data)
    inst_req = 1; inst_addr = 32'h100;
    tick();
    m_addr_ok = 1;
    tick();
    m_addr_ok = 0; inst_req = 0;
    @(negedge clk);
    chk("rst_in_resp_pre", m_req, 1'b0);
    reset = 1; m_rdata = 0;
    tick();
    reset = 0; m_data_ok = 1;
    @(negedge clk);
    chk("rst_outputs_zero", {m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, inst_rdata, data_rdata}, '0);
    tick();
    m_data_ok = 0;
    inst_req = 1; inst_addr = 32'h104; data_req = 1; data_addr = 32'h6000; data_wr = 0;
    tick();
    m_addr_ok = 1;
    @(negedge clk);
    chk("rst_first_grant_data", {m_addr, data_addr_ok, inst_addr_ok}, {32'h6000, 2'b10});
    tick();
    m_addr_ok = 0; inst_req = 0; data_req = 0; m_data_ok = 1;
    tick();
    m_data_ok = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_sram_arbiter.md
# cpu_sram_arbiter

Shares a single SRAM-like memory port between the instruction-fetch side and the data-access side of the pipeline. Sits between the IF/MEM stages and the memory bridge, and serialises their transactions with one transaction outstanding at a time. Arbitration is round-robin with data-side preference on ties. Read data is routed back to the side that owns the transaction, so MEM-stage load extraction (byte/half/LWL/LWR) sees a normal `data_rdata`/`data_data_ok` interface.

## Interface

Parameters:
- None.

Ports (name, direction, width, meaning):
- `clk` — in, 1 — clock.
- `reset` — in, 1 — synchronous, active-high.
- `inst_req` — in, 1 — fetch request; held stable until `inst_addr_ok`.
- `inst_addr` — in, 32 — fetch address.
- `inst_addr_ok` — out, 1 — one-cycle pulse: fetch address accepted.
- `inst_data_ok` — out, 1 — one-cycle pulse: `inst_rdata` valid.
- `inst_rdata` — out, 32 — fetch data.
- `data_req` — in, 1 — data request; held stable until `data_addr_ok`.
- `data_wr` — in, 1 — 1 = store, 0 = load.
- `data_size` — in, 2 — 0 = byte, 1 = half, 2 = word.
- `data_wstrb` — in, 4 — byte write strobes.
- `data_addr` — in, 32 — data address.
- `data_wdata` — in, 32 — store data.
- `data_addr_ok` — out, 1 — pulse: data address accepted.
- `data_data_ok` — out, 1 — pulse: load data valid or store complete.
- `data_rdata` — out, 32 — load data.
- `m_req` — out, 1 — memory-port request.
- `m_wr` — out, 1 — memory-port write enable.
- `m_size` — out, 2 — memory-port access size.
- `m_wstrb` — out, 4 — memory-port byte strobes.
- `m_addr` — out, 32 — memory-port address.
- `m_wdata` — out, 32 — memory-port write data.
- `m_addr_ok` — in, 1 — memory port accepted the request.
- `m_data_ok` — in, 1 — memory port response valid.
- `m_rdata` — in, 32 — memory-port read data.

## Operation

- **FSM states:** IDLE, ADDR, RESP.
- **Registers:** `owner` (0 = inst, 1 = data) and `last` (owner of the last completed transaction). Both reset to 0.
- **IDLE:**
  - Neither request asserted: stay in IDLE.
  - Exactly one request asserted: latch that side into `owner`, go to ADDR.
  - Both requests asserted: grant the side that is not `last`. If `last` = inst, data wins; if `last` = data, inst wins. Go to ADDR.
- **ADDR:**
  - `m_req` = 1.
  - `m_wr`, `m_size`, `m_wstrb`, `m_addr`, `m_wdata` are driven combinationally from the owner's inputs.
  - For inst ownership: `m_wr` = 0, `m_size` = 2, `m_wstrb` = 0, `m_wdata` = 0.
  - On `m_addr_ok`: pulse the owner's `*_addr_ok` in the same cycle (combinational), go to RESP.
- **RESP:**
  - `m_req` = 0.
  - On `m_data_ok`: pulse the owner's `*_data_ok` in the same cycle and route `m_rdata` to the owner's `*_rdata`. Set `last` to `owner`, go to IDLE.
- `m_data_ok` arriving outside RESP is ignored and produces no pulses.
- `*_addr_ok` and `*_data_ok` are never asserted to the non-owner side.
- `inst_rdata` and `data_rdata` are both continuously driven from `m_rdata`. They are qualified only by their `*_data_ok`.
- A request deasserting during ADDR is a master protocol violation. The arbiter keeps `m_req` = 1 until `m_addr_ok` regardless.
- **Reset**, including mid-transaction:
  - State returns to IDLE; `owner` and `last` return to 0.
  - All outputs become 0 in the cycle after reset is sampled.
  - An in-flight memory-port response is dropped; the memory port is reset by the same signal.

## Timing

- **Reset values:** all outputs 0, state IDLE.
- **Request latency:**
  - A request sampled in IDLE at cycle N gives `m_req` = 1 at cycle N+1.
  - `*_addr_ok` pulses in the same cycle as `m_addr_ok`.
  - Minimum issue latency is 1 cycle.
- **Response latency:** `*_data_ok` pulses in the same cycle as `m_data_ok`, with zero added latency.
- **Throughput:** one transaction per (2 + memory latency) cycles minimum. IDLE costs one cycle between transactions.
- **Single outstanding:** no new `m_req` is issued while in RESP.
- **`m_addr_ok` held low:** the FSM stays in ADDR indefinitely with the request fields stable.
- **No combinational path** from `inst_req`/`data_req` to `m_req`. `m_req` is a state decode.

## Test plan

- **Single load:**
  - Stimulus: `data_req` = 1, `data_wr` = 0, `data_addr` = 0x1000; memory gives `m_addr_ok` at cycle 2 and `m_data_ok` at cycle 4 with `m_rdata` = 0xDEADBEEF.
  - Required: `m_req` high in cycles 1–2, `m_addr` = 0x1000; `data_addr_ok` pulses at cycle 2; `data_data_ok` pulses at cycle 4 with `data_rdata` = 0xDEADBEEF; `inst_*_ok` stay 0 throughout.
- **Simultaneous requests after reset:**
  - Stimulus: `inst_req` and `data_req` both held high.
  - Required: data is granted first (`last` = 0 after reset), then inst, then data; the grant strictly alternates across 6 transactions.
- **Store sideband passthrough:**
  - Stimulus: `data_wr` = 1, `data_size` = 0, `data_wstrb` = 4'b0100, `data_wdata` = 0x00AB0000, `data_addr` = 0x2002.
  - Required: the `m_*` fields equal those values while `m_req` = 1.
- **Stalled memory port:**
  - Stimulus: `m_addr_ok` held 0 for 10 cycles during an inst fetch, with `data_req` raised meanwhile.
  - Required: `m_addr` stays equal to `inst_addr` and `m_req` stays 1; no data grant until the fetch's `m_data_ok`.
- **Stray response:**
  - Stimulus: `m_data_ok` pulsed while in IDLE.
  - Required: no `*_data_ok` pulse, and the state is unchanged.
- **Reset in RESP:**
  - Stimulus: `reset` asserted at a cycle after `m_addr_ok` and before `m_data_ok`.
  - Required: all outputs are 0 the next cycle; the FSM is in IDLE; the first grant after reset goes to data if both request.
